// File: rtl/address_unit.sv
// address_unit: PC / DIR / IND registers and address bus mux; RESET_VECTOR_EN adds the reset-vector fetch FSM.
module address_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        increment_pc,
    input  logic        pc_load,
    input  logic        dirl_load,
    input  logic        dirh_load,
    input  logic        indirl_load,
    input  logic        indirh_load,
    input  logic [1:0]  address_select,
    input  logic [7:0]  index,
    input  logic        index_en,
    output logic [15:0] address,
    output logic [15:0] pc,
    output logic        page_cross,
    output logic        busy
);
    logic [7:0]  dirl, dirh, indl, indh, idx;
    logic [8:0]  lo_sum;
    logic [15:0] run_addr, pc_run, pc_next;
    logic        run;

    always_comb begin
        idx      = index_en ? index : 8'h00;
        lo_sum   = {1'b0, dirl} + {1'b0, idx};
        pc_run   = pc_load ? {dirh, dirl} : increment_pc ? pc + 16'd1 : pc;
        run_addr = address_select == 2'b00 ? pc :
                   address_select == 2'b01 ? {8'h00, lo_sum[7:0]} :
                   address_select == 2'b10 ? {dirh, dirl} + {8'h00, idx} :
                                             {indh, indl};
    end

    assign page_cross = run & (address_select == 2'b10) & index_en & lo_sum[8];

`ifdef RESET_VECTOR_EN
    localparam logic [15:0] VECTOR_ADDR = 16'hFFFC;
    localparam logic [15:0] PC_INIT     = 16'h0000;

    typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} state_t;
    state_t state, state_next;

    always_ff @(posedge clk)
        state <= rst ? state_next : VEC_LO;

    // Vector bytes land straight in the PC halves; control inputs are ignored until RUN.
    always_comb begin
        state_next = state == VEC_LO ? VEC_HI : RUN;
        run        = state == RUN;
        busy       = !run;
        address    = state == VEC_LO ? VECTOR_ADDR :
                     state == VEC_HI ? VECTOR_ADDR + 16'd1 : run_addr;
        pc_next    = state == VEC_LO ? {pc[15:8], data_in} :
                     state == VEC_HI ? {data_in, pc[7:0]} : pc_run;
    end
`else
    localparam logic [15:0] PC_INIT = 16'h0200;

    assign run     = 1'b1;
    assign busy    = 1'b0;
    assign address = run_addr;
    assign pc_next = pc_run;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc   <= PC_INIT;
            dirl <= 8'h00;
            dirh <= 8'h00;
            indl <= 8'h00;
            indh <= 8'h00;
        end else begin
            pc <= pc_next;
            if (run && dirl_load)   dirl <= data_in;
            if (run && dirh_load)   dirh <= data_in;
            if (run && indirl_load) indl <= data_in;
            if (run && indirh_load) indh <= data_in;
        end
    end
endmodule

// File: tb/tb_address_unit.sv
// tb_address_unit: directed checks of address_unit in either RESET_VECTOR_EN build.
module tb_address_unit;
    logic        clk = 0, rst = 0;
    logic [7:0]  data_in = 0, index = 0;
    logic        increment_pc = 0, pc_load = 0, dirl_load = 0, dirh_load = 0;
    logic        indirl_load = 0, indirh_load = 0, index_en = 0;
    logic [1:0]  address_select = 0;
    logic [15:0] address, pc;
    logic        page_cross, busy;
    int          n_checks = 0, n_fail = 0;

    address_unit dut (
        .clk(clk), .rst(rst), .data_in(data_in), .increment_pc(increment_pc),
        .pc_load(pc_load), .dirl_load(dirl_load), .dirh_load(dirh_load),
        .indirl_load(indirl_load), .indirh_load(indirh_load),
        .address_select(address_select), .index(index), .index_en(index_en),
        .address(address), .pc(pc), .page_cross(page_cross), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_dir(input logic [7:0] h, input logic [7:0] l);
        data_in = l; dirl_load = 1; tick(); dirl_load = 0;
        data_in = h; dirh_load = 1; tick(); dirh_load = 0;
    endtask

    initial begin
        tick(); tick();
`ifdef RESET_VECTOR_EN
        check("rst_addr", address, 16'hFFFC);
        check("rst_busy", 16'(busy), 16'h1);
        check("rst_pc", pc, 16'h0000);
        check("rst_pcross", 16'(page_cross), 16'h0);
        rst = 1; data_in = 8'h34; increment_pc = 1; #1;
        check("vec_lo_addr", address, 16'hFFFC);
        tick();
        data_in = 8'h12;
        check("vec_hi_addr", address, 16'hFFFD);
        check("vec_hi_busy", 16'(busy), 16'h1);
        tick();
        increment_pc = 0;
        check("vec_done_busy", 16'(busy), 16'h0);
        check("vec_pc", pc, 16'h1234);
        check("vec_run_addr", address, 16'h1234);
`else
        check("rst_addr", address, 16'h0200);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_pc", pc, 16'h0200);
        check("rst_pcross", 16'(page_cross), 16'h0);
        rst = 1;
`endif
        load_dir(8'hFF, 8'hFF);
        pc_load = 1; tick(); pc_load = 0;
        check("pc_load_ffff", pc, 16'hFFFF);
        increment_pc = 1; #1;
        check("pc_addr_old", address, 16'hFFFF);
        tick(); increment_pc = 0;
        check("pc_wrap", pc, 16'h0000);
        load_dir(8'h12, 8'h80);
        pc_load = 1; increment_pc = 1; tick(); pc_load = 0;
        check("pc_priority", pc, 16'h1280);
        tick(); increment_pc = 0;
        check("pc_inc", pc, 16'h1281);

        load_dir(8'h00, 8'hF0);
        address_select = 2'b01; index = 8'h20; index_en = 1; #1;
        check("zp_wrap", address, 16'h0010);
        check("zp_pcross", 16'(page_cross), 16'h0);
        index_en = 0; #1;
        check("zp_noidx", address, 16'h00F0);

        load_dir(8'h20, 8'hFF);
        address_select = 2'b10; index = 8'h01; index_en = 1; #1;
        check("abs_cross", address, 16'h2100);
        check("abs_pcross", 16'(page_cross), 16'h1);
        index_en = 0; #1;
        check("abs_noidx", address, 16'h20FF);
        check("abs_noidx_pc", 16'(page_cross), 16'h0);
        address_select = 2'b01; index_en = 1; #1;
        check("zp_carry_pc", 16'(page_cross), 16'h0);
        check("zp_ff_wrap", address, 16'h0000);
        load_dir(8'hFF, 8'hFF);
        address_select = 2'b10; #1;
        check("abs_wrap", address, 16'h0000);
        check("abs_wrap_pc", 16'(page_cross), 16'h1);
        index_en = 0;

        data_in = 8'h00; indirl_load = 1; tick(); indirl_load = 0;
        data_in = 8'h30; indirh_load = 1; tick(); indirh_load = 0;
        address_select = 2'b11; #1;
        check("ind", address, 16'h3000);
        data_in = 8'h55; dirl_load = 1; dirh_load = 1; indirl_load = 1; indirh_load = 1; #1;
        check("ind_old", address, 16'h3000);
        tick();
        dirl_load = 0; dirh_load = 0; indirl_load = 0; indirh_load = 0;
        check("ind_all", address, 16'h5555);
        address_select = 2'b10; #1;
        check("abs_all", address, 16'h5555);

        address_select = 2'b00;
`ifdef RESET_VECTOR_EN
        rst = 0; tick(); rst = 1;
        data_in = 8'hAB; tick();
        check("midvec_hi", address, 16'hFFFD);
        rst = 0; tick(); rst = 1;
        check("midvec_addr", address, 16'hFFFC);
        check("midvec_pc", pc, 16'h0000);
        check("midvec_busy", 16'(busy), 16'h1);
`else
        rst = 0; tick(); rst = 1;
        check("rerst_pc", pc, 16'h0200);
        check("rerst_addr", address, 16'h0200);
        check("rerst_ind", {15'h0, busy}, 16'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
